// File: rtl/hit_judge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hit_judge : rhythm-game hit judgement (PERFECT/GOOD/MISS), score, combo  |
// | Option macro: HIT_JUDGE_COMBO_EN enables combo counter and combo bonus   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hit_judge #(
  parameter int PERF_WIN = 2_500_000,
  parameter int GOOD_WIN = 5_000_000,
  parameter int CNT_W    = 24
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Note,
  input  logic        i_Btn,
  output logic [1:0]  o_Sound_Cmd,
  output logic [15:0] o_Score,
  output logic [7:0]  o_Combo,
  output logic        o_Busy
);

  localparam logic [1:0]       c_CMD_NONE    = 2'd0;
  localparam logic [1:0]       c_CMD_PERFECT = 2'd1;
  localparam logic [1:0]       c_CMD_GOOD    = 2'd2;
  localparam logic [1:0]       c_CMD_MISS    = 2'd3;
  localparam logic [CNT_W-1:0] c_CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_PERF        = CNT_W'(PERF_WIN);
  localparam logic [CNT_W-1:0] c_GOOD        = CNT_W'(GOOD_WIN);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_btn_q;
  logic             w_press;
  logic [CNT_W-1:0] r_since_press;
  logic [CNT_W-1:0] w_since_eff;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_nxt;
  logic             w_consume;
  logic [1:0]       w_cmd;
  logic [1:0]       r_cmd;
  logic [15:0]      r_score;
  logic             w_hit;
  logic             w_bonus;
  logic [16:0]      w_score_sum;

  assign w_press     = i_Btn & ~r_btn_q;
  assign w_since_eff = w_press ? '0 : r_since_press;
  assign w_hit       = (w_cmd == c_CMD_PERFECT) || (w_cmd == c_CMD_GOOD);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_btn_q    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_btn_q    <= i_Btn;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_cmd       = c_CMD_NONE;
    w_consume   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_Note) begin
          if (w_since_eff <= c_PERF) begin
            w_cmd     = c_CMD_PERFECT;
            w_consume = 1'b1;
          end else if (w_since_eff <= c_GOOD) begin
            w_cmd     = c_CMD_GOOD;
            w_consume = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_wait_nxt  = '0;
          end
        end
      end
      WAIT: begin
        if (w_press) begin
          w_cmd     = (r_wait_cnt <= c_PERF) ? c_CMD_PERFECT : c_CMD_GOOD;
          w_consume = 1'b1;
          // A note arriving with the press sees an already-consumed press, so it always waits
          if (i_Note) begin
            w_state_nxt = WAIT;
            w_wait_nxt  = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (i_Note) begin
          w_cmd      = c_CMD_MISS;
          w_wait_nxt = '0;
        end else if (r_wait_cnt == c_GOOD) begin
          w_cmd       = c_CMD_MISS;
          w_state_nxt = IDLE;
        end else begin
          w_wait_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_since_press <= c_CNT_MAX;
    end else if (w_consume) begin
      r_since_press <= c_CNT_MAX;
    end else if (w_press) begin
      r_since_press <= '0;
    end else if (r_since_press != c_CNT_MAX) begin
      r_since_press <= r_since_press + CNT_W'(1);
    end
  end

`ifdef HIT_JUDGE_COMBO_EN
  logic [7:0] r_combo;

  assign w_bonus = w_hit && (r_combo >= 8'd10);
  assign o_Combo = r_combo;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_combo <= '0;
    end else if (w_cmd == c_CMD_MISS) begin
      r_combo <= '0;
    end else if (w_hit && (r_combo != 8'hFF)) begin
      r_combo <= r_combo + 8'd1;
    end
  end
`else
  assign w_bonus = 1'b0;
  assign o_Combo = '0;
`endif

  assign w_score_sum = {1'b0, r_score}
                     + ((w_cmd == c_CMD_PERFECT) ? 17'd2 : 17'd0)
                     + ((w_cmd == c_CMD_GOOD)    ? 17'd1 : 17'd0)
                     + (w_bonus                  ? 17'd1 : 17'd0);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_cmd   <= c_CMD_NONE;
      r_score <= '0;
    end else begin
      r_cmd   <= w_cmd;
      r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    end
  end

  assign o_Sound_Cmd = r_cmd;
  assign o_Score     = r_score;
  assign o_Busy      = (r_state == WAIT);

endmodule
`default_nettype wire

// File: tb/tb_hit_judge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hit_judge : scoreboard bench for hit_judge (PERF_WIN=4, GOOD_WIN=8)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_hit_judge;

  localparam int PERF_WIN = 4;
  localparam int GOOD_WIN = 8;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        note;
  logic        btn;
  logic [1:0]  sound_cmd;
  logic [15:0] score;
  logic [7:0]  combo;
  logic        busy;

  hit_judge #(
    .PERF_WIN(PERF_WIN),
    .GOOD_WIN(GOOD_WIN),
    .CNT_W   (CNT_W)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Note     (note),
    .i_Btn      (btn),
    .o_Sound_Cmd(sound_cmd),
    .o_Score    (score),
    .o_Combo    (combo),
    .o_Busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] cmd;
  } judge_t;

  typedef struct {
    logic        busy;
    logic [15:0] score;
    logic [7:0]  combo;
  } state_exp_t;

  judge_t     judge_q[$];
  state_exp_t state_q[$];
  int         edge_no = 0;
  int         checks  = 0;
  int         errors  = 0;

  always @(posedge clk) edge_no <= edge_no + 1;

  // Reference model: notes and presses tracked by the cycle number they occurred in
  bit m_pending = 1'b0;
  int m_ps      = 0;
  bit m_have    = 1'b0;
  int m_lp      = 0;
  bit m_prev    = 1'b0;
  int m_score   = 0;
  int m_combo   = 0;

  task automatic step(input bit r, input bit n_in, input bit b);
    int         n;
    int         w;
    int         eff;
    int         pts;
    bit         press;
    logic [1:0] cmd;
    judge_t     j;
    state_exp_t s;
    @(negedge clk);
    rst  = r;
    note = n_in;
    btn  = b;
    n    = edge_no + 1;
    cmd  = 2'd0;
    if (r) begin
      m_pending = 1'b0;
      m_have    = 1'b0;
      m_score   = 0;
      m_combo   = 0;
    end else begin
      press = b && !m_prev;
      if (m_pending) begin
        w = n - m_ps - 1;
        if (press) begin
          cmd       = (w <= PERF_WIN) ? 2'd1 : 2'd2;
          m_pending = 1'b0;
          m_have    = 1'b0;
          if (n_in) begin
            m_pending = 1'b1;
            m_ps      = n;
          end
        end else if (n_in) begin
          cmd  = 2'd3;
          m_ps = n;
        end else if (w == GOOD_WIN) begin
          cmd       = 2'd3;
          m_pending = 1'b0;
        end
      end else if (n_in) begin
        if (press) eff = 0;
        else if (m_have) eff = (n - m_lp - 1 > CNT_MAX) ? CNT_MAX : n - m_lp - 1;
        else eff = CNT_MAX;
        if (eff <= PERF_WIN) begin
          cmd    = 2'd1;
          m_have = 1'b0;
        end else if (eff <= GOOD_WIN) begin
          cmd    = 2'd2;
          m_have = 1'b0;
        end else begin
          m_pending = 1'b1;
          m_ps      = n;
        end
      end else if (press) begin
        m_have = 1'b1;
        m_lp   = n;
      end
      if (cmd == 2'd1 || cmd == 2'd2) begin
        pts = (cmd == 2'd1) ? 2 : 1;
`ifdef HIT_JUDGE_COMBO_EN
        if (m_combo >= 10) pts = pts + 1;
        m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
`endif
        m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
      end else if (cmd == 2'd3) begin
        m_combo = 0;
      end
      if (cmd != 2'd0) begin
        j.cyc = n;
        j.cmd = cmd;
        judge_q.push_back(j);
      end
    end
    m_prev  = r ? 1'b0 : b;
    s.busy  = m_pending;
    s.score = 16'(m_score);
    s.combo = 8'(m_combo);
    state_q.push_back(s);
  endtask

  // Monitor: every cycle's registered outputs against the queued expectations
  initial begin : monitor
    state_exp_t s;
    judge_t     j;
    forever begin
      @(posedge clk);
      #1;
      if (state_q.size() > 0) begin
        s = state_q.pop_front();
        checks++;
        if ({busy, score, combo} !== {s.busy, s.score, s.combo}) begin
          errors++;
          if (errors < 30)
            $display("FAIL state @edge %0d: busy/score/combo got %0b/%0d/%0d want %0b/%0d/%0d",
                     edge_no, busy, score, combo, s.busy, s.score, s.combo);
        end
      end
      while (judge_q.size() > 0 && judge_q[0].cyc < edge_no) begin
        j = judge_q.pop_front();
        checks++;
        errors++;
        if (errors < 30)
          $display("FAIL missed judgement @edge %0d: got none want cmd %0d", j.cyc, j.cmd);
      end
      checks++;
      if (judge_q.size() > 0 && judge_q[0].cyc == edge_no) begin
        j = judge_q.pop_front();
        if (sound_cmd !== j.cmd) begin
          errors++;
          if (errors < 30)
            $display("FAIL sound_cmd @edge %0d: got %0d want %0d", edge_no, sound_cmd, j.cmd);
        end
      end else if (sound_cmd !== 2'd0) begin
        errors++;
        if (errors < 30)
          $display("FAIL spurious sound_cmd @edge %0d: got %0d want 0", edge_no, sound_cmd);
      end
    end
  end

  initial begin : driver
    bit bl;
    rst  = 1'b1;
    note = 1'b0;
    btn  = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    // press three cycles ahead of the note
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0);
    // note, then late press
    step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    // note timing out
    step(1'b0, 1'b1, 1'b0);
    repeat (14) step(1'b0, 1'b0, 1'b0);
    // two notes three cycles apart
    step(1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (14) step(1'b0, 1'b0, 1'b0);
    // press and new note in the same WAIT cycle
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (14) step(1'b0, 1'b0, 1'b0);
    // lone press, then a note far past saturation
    step(1'b0, 1'b0, 1'b1);
    repeat (300) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0);
    // eleven PERFECTs then a MISS
    repeat (11) begin
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0);
    // reset while a note is pending
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0);
    // randomized traffic
    bl = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 2) == 0) bl = ~bl;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), bl);
    end
    repeat (12) step(1'b0, 1'b0, 1'b0);
    // score saturation
    repeat (32800) begin
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
    repeat (5) step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    checks++;
    if (judge_q.size() != 0 || state_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d queued entries want 0/0", judge_q.size(), state_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
